// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage DLX pipeline: owns the PC, fetches over imem req/ready, loads IF/ID.
// Optional statistics counters are built when IF_STATS_EN is defined.
module instruction_fetch #(
   parameter int              SIZE      = 32,
   parameter logic [SIZE-1:0] RESET_PC  = '0,
   parameter logic [SIZE-1:0] NOP_INSTR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_in,
   input  logic            redirect_in,
   input  logic [SIZE-1:0] redirect_pc_in,
   output logic            imem_req_out,
   output logic [SIZE-1:0] imem_addr_out,
   input  logic            imem_ready_in,
   input  logic [SIZE-1:0] imem_data_in,
   output logic [SIZE-1:0] instruction_out,
   output logic [SIZE-1:0] nextPC_out,
   output logic            valid_out,
   output logic [31:0]     fetch_count_out,
   output logic [31:0]     stall_count_out
);

   typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

   state_t          state, state_n;
   logic [SIZE-1:0] pc, pc_n, drain_addr, drain_addr_n;
   logic [SIZE-1:0] ifid_instr, ifid_instr_n, ifid_npc, ifid_npc_n;
   logic            ifid_vld, ifid_vld_n;
   logic [SIZE-1:0] hold_instr, hold_instr_n, hold_npc, hold_npc_n;
   logic            load_vld;
   logic [SIZE-1:0] pc_plus4, target;

   assign pc_plus4 = pc + SIZE'(4);
   assign target   = {redirect_pc_in[SIZE-1:2], 2'b00};

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      ifid_instr_n = ifid_instr;
      ifid_npc_n   = ifid_npc;
      ifid_vld_n   = ifid_vld;
      hold_instr_n = hold_instr;
      hold_npc_n   = hold_npc;
      load_vld     = 1'b0;
      case (state)
         RUN: begin
            if (redirect_in) begin
               pc_n         = target;
               ifid_instr_n = NOP_INSTR;
               ifid_vld_n   = 1'b0;
               // The outstanding request must still complete at its original address.
               if (!imem_ready_in) begin
                  state_n      = DRAIN;
                  drain_addr_n = pc;
               end
            end else if (imem_ready_in && !stall_in) begin
               ifid_instr_n = imem_data_in;
               ifid_npc_n   = pc_plus4;
               ifid_vld_n   = 1'b1;
               pc_n         = pc_plus4;
               load_vld     = 1'b1;
            end else if (imem_ready_in) begin
               hold_instr_n = imem_data_in;
               hold_npc_n   = pc_plus4;
               pc_n         = pc_plus4;
               state_n      = HOLD;
            end else if (!stall_in) begin
               ifid_instr_n = NOP_INSTR;
               ifid_vld_n   = 1'b0;
            end
         end
         HOLD: begin
            if (redirect_in) begin
               pc_n         = target;
               ifid_instr_n = NOP_INSTR;
               ifid_vld_n   = 1'b0;
               hold_instr_n = '0;
               hold_npc_n   = '0;
               state_n      = RUN;
            end else if (!stall_in) begin
               ifid_instr_n = hold_instr;
               ifid_npc_n   = hold_npc;
               ifid_vld_n   = 1'b1;
               load_vld     = 1'b1;
               state_n      = RUN;
            end
         end
         DRAIN: begin
            ifid_instr_n = NOP_INSTR;
            ifid_vld_n   = 1'b0;
            if (redirect_in)   pc_n    = target;
            if (imem_ready_in) state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         drain_addr <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_npc   <= '0;
         ifid_vld   <= 1'b0;
         hold_instr <= '0;
         hold_npc   <= '0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         drain_addr <= drain_addr_n;
         ifid_instr <= ifid_instr_n;
         ifid_npc   <= ifid_npc_n;
         ifid_vld   <= ifid_vld_n;
         hold_instr <= hold_instr_n;
         hold_npc   <= hold_npc_n;
      end
   end

   assign imem_req_out    = !reset && (state != HOLD);
   assign imem_addr_out   = (state == DRAIN) ? drain_addr : pc;
   assign instruction_out = ifid_instr;
   assign nextPC_out      = ifid_npc;
   assign valid_out       = ifid_vld;

`ifdef IF_STATS_EN
   logic [31:0] fetch_cnt, stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (load_vld) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_in) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign fetch_count_out = fetch_cnt;
   assign stall_count_out = stall_cnt;
`else
   logic unused_load_vld;
   assign unused_load_vld = load_vld;
   assign fetch_count_out = '0;
   assign stall_count_out = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized bench for instruction_fetch; a program-order model checks what ID consumes.
module tb_instruction_fetch;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0, ready = 1'b0;
   logic [31:0] target = '0;
   logic        req, valid;
   logic [31:0] addr, data, instr, npc, fcnt, scnt;

   int pass_cnt = 0, total_cnt = 0;
   logic [31:0] exp_pc = '0, paddr = '0;
   int          consumed = 0, flushed = 0, stalls = 0;
   bit          pending = 0, was_redirect = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   assign data = mem_word(addr);

   instruction_fetch dut (
      .clk(clk), .reset(reset), .stall_in(stall), .redirect_in(redirect),
      .redirect_pc_in(target), .imem_req_out(req), .imem_addr_out(addr),
      .imem_ready_in(ready), .imem_data_in(data), .instruction_out(instr),
      .nextPC_out(npc), .valid_out(valid), .fetch_count_out(fcnt), .stall_count_out(scnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Model update from pre-edge values, one clock, then rule checks on the result.
   task automatic cycle();
      #1;
      was_redirect = 0;
      if (reset) begin
         consumed = 0; flushed = 0; stalls = 0; exp_pc = '0; pending = 0;
      end else begin
         pending = req && !ready;
         paddr   = addr;
         if (redirect) begin
            was_redirect = 1;
            if (valid) flushed++;
            exp_pc = {target[31:2], 2'b00};
         end else if (!stall && valid) begin
            chk("consume_instr", instr, mem_word(exp_pc));
            chk("consume_npc", npc, exp_pc + 32'd4);
            consumed++;
            exp_pc = exp_pc + 32'd4;
         end
         if (stall) stalls++;
      end
      @(negedge clk);
      if (pending) begin
         chk("req_held", {31'd0, req}, 32'd1);
         chk("addr_held", addr, paddr);
      end
      if (was_redirect) chk("flush_valid", {31'd0, valid}, 32'd0);
`ifdef IF_STATS_EN
      chk("stall_count", scnt, 32'(stalls));
      chk("fetch_count", fcnt, 32'(consumed + flushed + int'(valid)));
`else
      chk("stall_count_off", scnt, 32'd0);
      chk("fetch_count_off", fcnt, 32'd0);
`endif
   endtask

   task automatic chk_reset_vals();
      chk("rst_instr", instr, 32'h0);
      chk("rst_npc", npc, 32'h0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_fcnt", fcnt, 32'd0);
      chk("rst_scnt", scnt, 32'd0);
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] a);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
      chk({tag, "_instr"}, instr, mem_word(a));
      chk({tag, "_npc"}, npc, a + 32'd4);
   endtask

   initial begin
      // reset
      @(negedge clk);
      reset = 1'b1;
      #1 chk("req_in_reset", {31'd0, req}, 32'd0);
      cycle();
      chk_reset_vals();
      cycle();
      reset = 1'b0;
      #1 chk("req_after_reset", {31'd0, req}, 32'd1);
      chk("addr_after_reset", addr, 32'h0);

      // T1: back-to-back fetches
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t1_addr", addr, 32'(i * 4));
         cycle();
         chk_ifid("t1", 32'(i * 4));
      end

      // T2: two wait states at 0x10
      redirect = 1'b1; target = 32'h10; cycle();
      redirect = 1'b0; ready = 1'b0;
      #1 chk("t2_addr0", addr, 32'h10);
      cycle();
      chk("t2_bubble", {31'd0, valid}, 32'd0);
      chk("t2_addr1", addr, 32'h10);
      cycle();
      ready = 1'b1;
      chk("t2_addr2", addr, 32'h10);
      cycle();
      chk_ifid("t2", 32'h10);

      // T3: stall for 3 cycles as 0x20 returns
      redirect = 1'b1; target = 32'h1C; cycle();
      redirect = 1'b0; cycle();
      chk_ifid("t3_prior", 32'h1C);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_ifid("t3_held", 32'h1C);
         #1 chk("t3_req_off", {31'd0, req}, 32'd0);
      end
      stall = 1'b0; cycle();
      chk_ifid("t3_rel", 32'h20);
      chk("t3_next_addr", addr, 32'h24);
      cycle();
      chk_ifid("t3_after", 32'h24);

      // T4: redirect to 0x103 while 0x40 waits
      redirect = 1'b1; target = 32'h40; cycle();
      redirect = 1'b0; ready = 1'b0; cycle();
      chk("t4_wait_addr", addr, 32'h40);
      redirect = 1'b1; target = 32'h103; cycle();
      chk("t4_bubble", {31'd0, valid}, 32'd0);
      redirect = 1'b0; ready = 1'b1;
      #1 chk("t4_stale_addr", addr, 32'h40);
      cycle();
      chk("t4_drop", {31'd0, valid}, 32'd0);
      chk("t4_new_addr", addr, 32'h100);
      cycle();
      chk_ifid("t4", 32'h100);

      // T5: wrap, then reset while draining
      redirect = 1'b1; target = 32'hFFFFFFFC; cycle();
      redirect = 1'b0;
      chk("t5_top_addr", addr, 32'hFFFFFFFC);
      cycle();
      chk("t5_wrap_npc", npc, 32'h0);
      chk("t5_wrap_addr", addr, 32'h0);
      cycle();
      ready = 1'b0; redirect = 1'b1; target = 32'h200; cycle();
      redirect = 1'b0; reset = 1'b1; ready = 1'b1;
      #1 chk("t5_req_in_reset", {31'd0, req}, 32'd0);
      cycle();
      chk_reset_vals();
      reset = 1'b0;
      #1 chk("t5_addr_after_reset", addr, 32'h0);

      // T6: 10 deliveries then 4 stall cycles
      for (int i = 0; i < 10; i++) cycle();
      stall = 1'b1; ready = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
`ifdef IF_STATS_EN
      chk("t6_fetch", fcnt, 32'd10);
      chk("t6_stall", scnt, 32'd4);
`else
      chk("t6_fetch_off", fcnt, 32'd0);
      chk("t6_stall_off", scnt, 32'd0);
`endif

      // randomized traffic against the program-order model
      for (int i = 0; i < 600; i++) begin
         ready    = ($urandom_range(0, 2) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 15) == 0);
         target   = (i % 50 == 25) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 3)) : $urandom;
         reset    = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
